fp16b_addsub_arbiter: RTL and testbench
=======================================

# fp16b_addsub_arbiter

Round-robin arbiter and scheduler that shares one fixed-latency, non-stallable bfloat16 add/sub pipeline between NUM_REQ requesters. It sits between the requesters and the 5-stage FP16B add/sub unit. It issues at most one operation per cycle into the unit and tracks each operation's requester ID alongside the pipeline. Results are collected in a credit-protected FIFO and returned in issue order with their requester ID.

## Interface
- NUM_REQ, 4: number of requesters, 2..2**ID_W.
- ID_W, 2: requester-ID width.
- LATENCY, 5: cycles from operands present on unit_arg_* to valid unit_ret_0.
- FIFO_DEPTH, 8: result FIFO entries, which is also the maximum number of outstanding operations; must be >= 1.

Ports (direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- req_valid, in, NUM_REQ: per-requester operation request.
- req_ready, out, NUM_REQ: one-hot grant. Requester i is accepted on an edge where req_valid[i] & req_ready[i].
- req_x, in, 16*NUM_REQ: operand x of requester i at bits [16i+15:16i].
- req_y, in, 16*NUM_REQ: operand y, same packing.
- req_sub, in, NUM_REQ: 1 selects x-y, 0 selects x+y.
- unit_arg_0, out, 16: x to the add/sub unit (registered).
- unit_arg_1, out, 16: y to the add/sub unit (registered).
- unit_arg_2, out, 1: is_sub to the add/sub unit (registered).
- unit_ret_0, in, 16: result from the add/sub unit.
- rsp_valid, out, 1: the FIFO head is valid.
- rsp_ready, in, 1: the consumer accepts the head.
- rsp_data, out, 16: result at the FIFO head.
- rsp_id, out, ID_W: requester index of the head.
- busy, out, 1: high while any operation is in flight or buffered.

## Operation
**Credit counter**
- credit_cnt ranges 0..FIFO_DEPTH and resets to FIFO_DEPTH.
- It decrements on accept and increments on pop (rsp_valid & rsp_ready). When both happen on the same edge it is unchanged.
- busy = (credit_cnt != FIFO_DEPTH).

**Arbitration**
- Pointer ptr resets to 0.
- Grant goes to the first i with req_valid[i] set, searching ptr, ptr+1, ... modulo NUM_REQ.
- req_ready is all-zero when credit_cnt == 0 or while rst is low. A pop on the same edge does not allow a bypass.
- req_ready is combinational from req_valid. Requesters must not make req_valid depend on req_ready.
- On an accept of requester i, ptr becomes (i+1) mod NUM_REQ. Without an accept, ptr holds.

**Issue**
- On an accept, the issue register loads the granted x, y and sub into unit_arg_*.
- Without an accept, unit_arg_* hold their previous values.
- An issue-valid bit plus ID enter a tag shift register of depth LATENCY+1, aligned so the tag emerges in the cycle unit_ret_0 carries that operation's result.

**Capture**
- When the emerging tag is valid, {unit_ret_0, id} is written into the FIFO.
- By construction of the credit counter the FIFO is never full on a write. An overflow assertion must never fire.

**Response**
- The FIFO is first-word-fall-through: rsp_data and rsp_id show the head, and rsp_valid = !empty.
- Order is strictly the issue order.
- Read and write on the same edge are allowed at any occupancy, including empty (the write is visible the next cycle) and FIFO_DEPTH-1.
- Pointers wrap modulo FIFO_DEPTH.

**Arithmetic**
- The block never inspects or modifies operand or result bits. All arithmetic is done by the unit.

**Reset (also mid-operation)**
- Clears ptr, the tag valids, the FIFO pointers and count, and the issue register, and sets credit_cnt to FIFO_DEPTH.
- Values still inside the unit are never captured, because their tags are cleared.

**Reset values of outputs**
- req_ready 0, unit_arg_0/1 0, unit_arg_2 0.
- rsp_valid 0, rsp_data 0, rsp_id 0, busy 0.

## Timing
- Accept at edge E0 puts the operands on unit_arg_* during cycle E0..E0+1.
- The result is captured at edge E0+LATENCY+1, and rsp_valid is high from then on. Accept-to-response latency is LATENCY+1 edges (6 by default).
- Throughput is one accept per cycle while credits remain.
- With rsp_ready held high, sustained throughput is 1/cycle whenever FIFO_DEPTH >= LATENCY+2.
- The pop takes effect on the edge where rsp_valid & rsp_ready; the next head appears after that edge.

## Test plan
- **Single add:** req 0, x=0x3F80, y=0x3F80, sub=0, accepted at edge k, rsp_ready=1 -> rsp_valid at edge k+6 with rsp_data=0x4000, rsp_id=0; busy drops the following edge.
- **Subtraction, both signs:** req 2 issues 0x4000-0x3F80, then 0x3F80-0x4000 -> rsp_data 0x3F80 then 0xBF80, both with rsp_id=2.
- **Round-robin fairness:** all four req_valid held high, rsp_ready=1 -> grants 0,1,2,3,0,1,... one per cycle, and responses return with ids in the same order, no gaps.
- **Credit backpressure:** rsp_ready=0, req 1 streaming -> exactly 8 accepts, then req_ready=0, rsp_valid=1, busy=1. One-cycle rsp_ready pulse -> one pop and exactly one more accept on the next edge, with no data lost or duplicated.
- **Simultaneous events:** with credit_cnt=1, an accept and a pop on the same edge -> credit_cnt stays 1. A FIFO read and write at occupancy 0 and at 7 keep the data order intact.
- **Reset mid-flight:** three ops in flight and one buffered, rst low for one cycle -> no rsp_valid afterwards, credit_cnt=8, the next grant starts from requester 0, and all outputs hold their reset values during reset.

Source files
------------

// File: rtl/fp16b_addsub_arbiter.sv
// Round-robin front end for a shared fixed-latency bfloat16 add/sub unit.
// Tracks requester IDs alongside the pipeline and returns results in issue order.
module fp16b_addsub_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned LATENCY    = 5,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [16*NUM_REQ-1:0]   req_x,
  input  logic [16*NUM_REQ-1:0]   req_y,
  input  logic [NUM_REQ-1:0]      req_sub,
  output logic [15:0]             unit_arg_0,
  output logic [15:0]             unit_arg_1,
  output logic                    unit_arg_2,
  input  logic [15:0]             unit_ret_0,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [15:0]             rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned SUM_W  = ID_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
  } entry_t;

  logic [ID_W-1:0]             ptr;
  logic [ID_W-1:0]             ptr_nxt;
  logic [ID_W-1:0]             grant_id;
  logic [SUM_W-1:0]            scan_idx;
  logic                        found;
  logic                        accept;
  logic                        pop;
  logic                        push;
  logic [DATA_W-1:0]           sel_x;
  logic [DATA_W-1:0]           sel_y;
  logic                        sel_sub;
  logic [CNT_W-1:0]            credit_cnt;
  logic [CNT_W-1:0]            fifo_cnt;
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [LATENCY:0]            tag_vld;
  logic [LATENCY:0][ID_W-1:0]  tag_id;
  entry_t                      mem [FIFO_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Round-robin search starting at ptr; no grant without a credit or in reset.
  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    found     = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      scan_idx = SUM_W'(ptr) + SUM_W'(k);
      if (scan_idx >= SUM_W'(NUM_REQ)) scan_idx = scan_idx - SUM_W'(NUM_REQ);
      if (!found && req_valid[scan_idx[ID_W-1:0]]) begin
        found    = 1'b1;
        grant_id = scan_idx[ID_W-1:0];
      end
    end
    if (found && rst && (credit_cnt != '0)) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    sel_x   = '0;
    sel_y   = '0;
    sel_sub = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (req_ready[i]) begin
        sel_x   = req_x[DATA_W*i +: DATA_W];
        sel_y   = req_y[DATA_W*i +: DATA_W];
        sel_sub = req_sub[i];
      end
    end
  end

  assign accept  = |req_ready;
  assign ptr_nxt = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
  assign push    = tag_vld[LATENCY];
  assign pop     = rsp_valid & rsp_ready;

  // Issue register, credits and the tag pipe that shadows the unit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr        <= '0;
      unit_arg_0 <= '0;
      unit_arg_1 <= '0;
      unit_arg_2 <= 1'b0;
      credit_cnt <= CNT_W'(FIFO_DEPTH);
      tag_vld    <= '0;
      tag_id     <= '0;
    end else begin
      if (accept) begin
        ptr        <= ptr_nxt;
        unit_arg_0 <= sel_x;
        unit_arg_1 <= sel_y;
        unit_arg_2 <= sel_sub;
      end
      case ({accept, pop})
        2'b10:   credit_cnt <= credit_cnt - CNT_W'(1);
        2'b01:   credit_cnt <= credit_cnt + CNT_W'(1);
        default: credit_cnt <= credit_cnt;
      endcase
      tag_vld <= {tag_vld[LATENCY-1:0], accept};
      tag_id  <= {tag_id[LATENCY-1:0], grant_id};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Storage needs no reset: reads are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{data: unit_ret_0, id: tag_id[LATENCY]};
  end

  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_data  = rsp_valid ? mem[rd_ptr].data : '0;
  assign rsp_id    = rsp_valid ? mem[rd_ptr].id : '0;
  assign busy      = (credit_cnt != CNT_W'(FIFO_DEPTH));

  fifo_overflow_a: assert property (@(posedge clk) disable iff (!rst)
    !(push && (fifo_cnt == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fp16b_addsub_arbiter.sv
// Bench for fp16b_addsub_arbiter: a bf16 unit model plus a queue-based scoreboard
// checked every cycle, with directed scenarios pinning literal results.
module tb_fp16b_addsub_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int LATENCY = 5;
  localparam int DEPTH   = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_x;
  logic [16*NUM_REQ-1:0] req_y;
  logic [NUM_REQ-1:0]    req_sub;
  logic [15:0]           unit_arg_0;
  logic [15:0]           unit_arg_1;
  logic                  unit_arg_2;
  logic [15:0]           unit_ret_0;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [15:0]           rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic                  busy;

  fp16b_addsub_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .LATENCY(LATENCY), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_sub(req_sub),
    .unit_arg_0(unit_arg_0), .unit_arg_1(unit_arg_1), .unit_arg_2(unit_arg_2),
    .unit_ret_0(unit_ret_0),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // bfloat16 arithmetic via exact double-precision sum and round-to-nearest-even.
  function automatic real bf2r(input logic [15:0] b);
    logic [63:0] d;
    if (b[14:7] == 8'd0) return 0.0;
    d = {b[15], 11'(b[14:7]) + 11'd896, b[6:0], 45'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [15:0] r2bf(input real r);
    logic [63:0] d;
    logic [10:0] e;
    logic [14:0] m;
    if (r == 0.0) return 16'h0000;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    m = {e[7:0], d[51:45]};
    if (d[44] && ((|d[43:0]) || m[0])) m = m + 15'd1;
    return {d[63], m};
  endfunction

  function automatic logic [15:0] bf16_op(input logic [15:0] x, input logic [15:0] y,
                                          input logic sub);
    return r2bf(sub ? (bf2r(x) - bf2r(y)) : (bf2r(x) + bf2r(y)));
  endfunction

  function automatic logic [15:0] rand_bf16();
    return {1'($urandom), 8'(120 + $urandom_range(0, 15)), 7'($urandom)};
  endfunction

  // Model of the external unit: LATENCY-cycle pipe behind the registered operands.
  logic [15:0] upipe [LATENCY];
  always @(posedge clk) begin
    upipe[0] <= bf16_op(unit_arg_0, unit_arg_1, unit_arg_2);
    for (int i = 1; i < LATENCY; i++) upipe[i] <= upipe[i-1];
  end
  assign unit_ret_0 = upipe[LATENCY-1];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard state: grant pointer, credits, in-flight ops and response queue.
  typedef struct {
    int          due;
    logic [15:0] d;
    int          id;
  } infl_t;

  int          m_ptr;
  int          m_credit;
  int          edge_n = 0;
  logic [15:0] m_a0;
  logic [15:0] m_a1;
  logic        m_a2;
  infl_t       infl[$];
  logic [15:0] fq_d[$];
  int          fq_id[$];

  always @(negedge clk) begin
    int                 g;
    logic [NUM_REQ-1:0] er;
    logic               mpop;
    infl_t              t;
    if (!rst) begin
      m_ptr = 0; m_credit = DEPTH; m_a0 = '0; m_a1 = '0; m_a2 = 1'b0;
      infl.delete(); fq_d.delete(); fq_id.delete();
      chk("rst_req_ready", 32'(req_ready), 32'(0));
      chk("rst_unit_args", {15'd0, unit_arg_2, unit_arg_1}, 32'(0));
      chk("rst_unit_arg0", 32'(unit_arg_0), 32'(0));
      chk("rst_rsp", {13'd0, rsp_valid, rsp_id, rsp_data}, 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
    end else begin
      g = -1;
      if (m_credit > 0)
        for (int k = 0; k < NUM_REQ; k++)
          if (g < 0 && req_valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
      er = (g >= 0) ? NUM_REQ'(1) << g : '0;
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("unit_arg_0", 32'(unit_arg_0), 32'(m_a0));
      chk("unit_arg_1", 32'(unit_arg_1), 32'(m_a1));
      chk("unit_arg_2", 32'(unit_arg_2), 32'(m_a2));
      chk("rsp_valid", 32'(rsp_valid), 32'(fq_d.size() > 0));
      if (fq_d.size() > 0) begin
        chk("rsp_data", 32'(rsp_data), 32'(fq_d[0]));
        chk("rsp_id", 32'(rsp_id), 32'(fq_id[0]));
      end
      chk("busy", 32'(busy), 32'(m_credit != DEPTH));
      // Advance to the state after the coming rising edge.
      edge_n++;
      mpop = (fq_d.size() > 0) && rsp_ready;
      if (mpop) begin
        void'(fq_d.pop_front());
        void'(fq_id.pop_front());
      end
      if (infl.size() > 0 && infl[0].due == edge_n) begin
        fq_d.push_back(infl[0].d);
        fq_id.push_back(infl[0].id);
        void'(infl.pop_front());
      end
      if (g >= 0) begin
        m_a0 = req_x[16*g +: 16];
        m_a1 = req_y[16*g +: 16];
        m_a2 = req_sub[g];
        t.due = edge_n + LATENCY + 1;
        t.d   = bf16_op(m_a0, m_a1, m_a2);
        t.id  = g;
        infl.push_back(t);
        m_ptr = (g + 1) % NUM_REQ;
      end
      m_credit = m_credit + (mpop ? 1 : 0) - ((g >= 0) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    while (busy && n < maxc) begin
      tick();
      n++;
    end
    chk("drain_idle", 32'(busy), 32'(0));
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_x[16*i +: 16] = rand_bf16();
      req_y[16*i +: 16] = rand_bf16();
      req_sub[i]        = 1'($urandom);
    end
  endtask

  initial begin
    int n;
    int acc;
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    req_x = '0; req_y = '0; req_sub = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Single add: 1.0 + 1.0 from requester 0.
    req_valid = 4'b0001; req_x[15:0] = 16'h3F80; req_y[15:0] = 16'h3F80;
    req_sub[0] = 1'b0; rsp_ready = 1'b1;
    #1 chk("t1_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    chk("t1_latency", 32'(n), 32'd6);
    chk("t1_data", 32'(rsp_data), 32'h4000);
    chk("t1_id", 32'(rsp_id), 32'd0);
    tick();
    chk("t1_busy_drop", 32'(busy), 32'd0);
    chk("t1_rsp_empty", 32'(rsp_valid), 32'd0);

    // Subtraction in both directions from requester 2.
    req_valid = 4'b0100; req_x[47:32] = 16'h4000; req_y[47:32] = 16'h3F80; req_sub[2] = 1'b1;
    #1 chk("t2_grant", 32'(req_ready), 32'h4);
    tick();
    req_x[47:32] = 16'h3F80; req_y[47:32] = 16'h4000;
    tick();
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    chk("t2_data0", 32'(rsp_data), 32'h3F80);
    chk("t2_id0", 32'(rsp_id), 32'd2);
    tick();
    chk("t2_valid1", 32'(rsp_valid), 32'd1);
    chk("t2_data1", 32'(rsp_data), 32'hBF80);
    chk("t2_id1", 32'(rsp_id), 32'd2);
    drain(40);

    // Credit backpressure with requester 1 streaming.
    rsp_ready = 1'b0; req_valid = 4'b0010; acc = 0;
    for (int c = 0; c < 14; c++) begin
      req_x[31:16] = rand_bf16(); req_y[31:16] = rand_bf16(); req_sub[1] = 1'($urandom);
      #1 if (req_ready[1]) acc++;
      tick();
    end
    chk("t3_accepts", 32'(acc), 32'd8);
    chk("t3_stalled", 32'(req_ready), 32'd0);
    chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t3_busy", 32'(busy), 32'd1);
    rsp_ready = 1'b1;
    #1 chk("t3_no_bypass", 32'(req_ready), 32'd0);
    tick();
    rsp_ready = 1'b0;
    #1 chk("t3_one_more", 32'(req_ready), 32'h2);
    tick();
    #1 chk("t3_stalled_again", 32'(req_ready), 32'd0);
    req_valid = '0; rsp_ready = 1'b1;
    tick();
    req_valid = 4'b0010;
    #1 chk("t3_credit1_grant", 32'(req_ready), 32'h2);
    tick();
    rsp_ready = 1'b0;
    #1 chk("t3_credit1_held", 32'(req_ready), 32'h2);
    tick();
    #1 chk("t3_credit0", 32'(req_ready), 32'd0);
    drain(100);

    // Reset while three ops are in flight and one is buffered.
    rsp_ready = 1'b0; req_valid = 4'b0010;
    tick();
    req_valid = '0;
    repeat (7) tick();
    req_valid = 4'b1000;
    repeat (3) tick();
    rst = 1'b0; req_valid = 4'b1111;
    #1;
    chk("t4_rst_ready", 32'(req_ready), 32'd0);
    chk("t4_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_args", {15'd0, unit_arg_2, unit_arg_0}, 32'd0);
    tick();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t4_no_rsp", 32'(rsp_valid), 32'd0);
      chk("t4_idle", 32'(busy), 32'd0);
    end

    // Round-robin with every requester asking; starts from requester 0 after reset.
    req_valid = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      randomize_ops();
      #1 chk("t5_rr_grant", 32'(req_ready), 32'(1) << (c % NUM_REQ));
      tick();
    end
    drain(60);

    // Randomized traffic with alternating consumer pressure.
    for (int blk = 0; blk < 8; blk++) begin
      for (int c = 0; c < 60; c++) begin
        randomize_ops();
        req_valid = NUM_REQ'($urandom);
        rsp_ready = (blk % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        tick();
      end
    end
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
